spi_mmio_master: RTL and testbench

Memory-mapped SPI master that sits in the memory stage of the five-stage RISC-V pipeline. It decodes the stage's ALU address, store data and memory-write strobe, and serialises stored bytes onto the SPI pins. It returns received bytes and status on loads in the same cycle, so the memory stage can mux them into its read-data path ahead of the MEM/WB register. It raises `spi_interrupt` when a transfer completes.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_shift_engine.sv | 120 ++++++++++++
 rtl/spi_mmio_master.sv | 130 +++++++++++++
 tb/tb_spi_mmio_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and register-map constants for the memory-mapped SPI master.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } spi_state_e;

   localparam logic [3:0] OFF_TX   = 4'h0;
   localparam logic [3:0] OFF_RX   = 4'h4;
   localparam logic [3:0] OFF_STAT = 4'h8;
   localparam logic [3:0] OFF_CTRL = 4'hC;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;

   // Byte address within the window, low two bits dropped (word-aligned map).
   function automatic logic [3:0] reg_offset(input logic [31:0] a);
      return {a[3:2], 2'b00};
   endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 frame engine: setup, 16 sclk half-periods, hold, with registered pins.
module spi_shift_engine
   import spi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] tx_byte_i,
   input  logic [7:0] div_i,
   input  logic       miso_i,
   output logic       busy_o,
   output logic       done_pulse_o,
   output logic [7:0] rx_byte_o,
   output logic       sclk_o,
   output logic       ss_o,
   output logic       mosi_o
);

   spi_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] edge_q, edge_d;
   logic [7:0] shift_q, shift_d;
   logic       samp_q, samp_d;
   logic       sclk_q, sclk_d;
   logic       ss_q, ss_d;
   logic       mosi_q, mosi_d;
   logic       done_pulse_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         edge_q  <= 4'd0;
         shift_q <= 8'd0;
         samp_q  <= 1'b0;
         sclk_q  <= 1'b0;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         shift_q <= shift_d;
         samp_q  <= samp_d;
         sclk_q  <= sclk_d;
         ss_q    <= ss_d;
         mosi_q  <= mosi_d;
      end
   end

   // Even edge index = sclk high: entering it samples miso; entering an odd one shifts.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      edge_d       = edge_q;
      shift_d      = shift_q;
      samp_d       = samp_q;
      done_pulse_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SETUP;
               cnt_d   = div_i;
               shift_d = tx_byte_i;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = SHIFT;
               cnt_d   = div_i;
               edge_d  = 4'd0;
               samp_d  = miso_i;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         SHIFT: begin
            if (cnt_q == 8'd0) begin
               cnt_d = div_i;
               if (edge_q == 4'd15) begin
                  state_d = HOLD;
               end else begin
                  edge_d = edge_q + 4'd1;
                  if (!edge_q[0]) begin
                     shift_d = {shift_q[6:0], samp_q};
                  end else begin
                     samp_d = miso_i;
                  end
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d      = IDLE;
               done_pulse_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      sclk_d = (state_d == SHIFT) && !edge_d[0];
      ss_d   = (state_d == IDLE);
      mosi_d = (state_d == IDLE) ? 1'b0 : shift_d[7];
   end

   assign busy_o       = (state_q != IDLE);
   assign done_pulse_o = done_pulse_s;
   assign rx_byte_o    = shift_q;
   assign sclk_o       = sclk_q;
   assign ss_o         = ss_q;
   assign mosi_o       = mosi_q;

endmodule

// File: rtl/spi_mmio_master.sv
// Memory-stage SPI master: address decode, register file and same-cycle load mux.
module spi_mmio_master
   import spi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter logic [7:0]  CLKDIV_RST = 8'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        sclk,
   output logic        ss,
   output logic        mosi,
   input  logic        miso,
   output logic        spi_interrupt
);

   logic [3:0] off_s;
   logic       busy_s, done_pulse_s, start_s;
   logic       tx_wr_s, rx_rd_s, stat_wr_s, ctrl_wr_s;
   logic [7:0] shift_rx_s;
   logic       unused_bits_s;

   logic [7:0] rx_byte_q, rx_byte_d;
   logic       done_q, done_d;
   logic       overrun_q, overrun_d;
   logic       irq_en_q, irq_en_d;
   logic [7:0] clkdiv_q, clkdiv_d;
   logic       irq_q, irq_d;

   assign off_s         = reg_offset(addr);
   assign sel           = (addr[31:4] == BASE_ADDR[31:4]);
   assign tx_wr_s       = sel && we && (off_s == OFF_TX);
   assign stat_wr_s     = sel && we && (off_s == OFF_STAT);
   assign ctrl_wr_s     = sel && we && (off_s == OFF_CTRL);
   assign rx_rd_s       = sel && re && (off_s == OFF_RX);
   assign start_s       = tx_wr_s && !busy_s;
   assign unused_bits_s = ^{wdata[31:9], addr[1:0]};

   spi_shift_engine u_engine (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_s),
      .tx_byte_i    (wdata[7:0]),
      .div_i        (clkdiv_q),
      .miso_i       (miso),
      .busy_o       (busy_s),
      .done_pulse_o (done_pulse_s),
      .rx_byte_o    (shift_rx_s),
      .sclk_o       (sclk),
      .ss_o         (ss),
      .mosi_o       (mosi)
   );

   // Completion wins over a same-cycle clear; busy covers the HOLD-exit cycle.
   always_comb begin
      rx_byte_d = rx_byte_q;
      done_d    = done_q;
      overrun_d = overrun_q;
      irq_en_d  = irq_en_q;
      clkdiv_d  = clkdiv_q;
      if (done_pulse_s) begin
         rx_byte_d = shift_rx_s;
         done_d    = 1'b1;
      end else if (rx_rd_s || (stat_wr_s && wdata[STAT_DONE])) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end
      if (tx_wr_s && busy_s) begin
         overrun_d = 1'b1;
      end else if (stat_wr_s && wdata[STAT_OVR]) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
      if (ctrl_wr_s) begin
         irq_en_d = wdata[8];
         if (!busy_s) begin
            clkdiv_d = wdata[7:0];
         end else begin
            clkdiv_d = clkdiv_q;
         end
      end else begin
         irq_en_d = irq_en_q;
      end
      irq_d = done_d && irq_en_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_byte_q <= 8'd0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         irq_en_q  <= 1'b0;
         clkdiv_q  <= CLKDIV_RST;
         irq_q     <= 1'b0;
      end else begin
         rx_byte_q <= rx_byte_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         irq_en_q  <= irq_en_d;
         clkdiv_q  <= clkdiv_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (sel) begin
         case (off_s)
            OFF_TX:   rdata = 32'd0;
            OFF_RX:   rdata = {24'd0, rx_byte_q};
            OFF_STAT: rdata = {29'd0, overrun_q, done_q, busy_s};
            OFF_CTRL: rdata = {23'd0, irq_en_q, clkdiv_q};
            default:  rdata = 32'd0;
         endcase
      end else begin
         rdata = 32'd0;
      end
   end

   assign spi_interrupt = irq_q;

endmodule

// File: tb/tb_spi_mmio_master.sv
// Scoreboard bench: stimulus schedules expected values per cycle, a monitor compares them.
module tb_spi_mmio_master;
   import spi_pkg::*;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic        we, re, sel, sclk, ss, mosi, miso, spi_interrupt;
   logic        loop_en, miso_val;

   always #5 clk = ~clk;
   assign miso = loop_en ? mosi : miso_val;

   spi_mmio_master #(.BASE_ADDR(32'h4000_0000), .CLKDIV_RST(8'd1)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .sel(sel), .rdata(rdata), .sclk(sclk), .ss(ss), .mosi(mosi),
      .miso(miso), .spi_interrupt(spi_interrupt)
   );

   typedef enum int {K_RDATA, K_SEL, K_SS, K_SCLK, K_MOSI, K_IRQ, K_SSLOW, K_RISE, K_SEQ} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] exp;
      string       name;
      int          due;
   } exp_t;

   exp_t       sb_q[$];
   int         cyc = 0;
   int         n_cmp = 0, n_err = 0;
   int         ss_low_cnt = 0, rise_cnt = 0;
   logic [7:0] mosi_seq = 8'h00;
   logic       sclk_prev = 1'b0;
   int         clr_req = 0, clr_seen = 0;
   int         t0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input kind_e k);
      case (k)
         K_RDATA: return rdata;
         K_SEL:   return {31'd0, sel};
         K_SS:    return {31'd0, ss};
         K_SCLK:  return {31'd0, sclk};
         K_MOSI:  return {31'd0, mosi};
         K_IRQ:   return {31'd0, spi_interrupt};
         K_SSLOW: return ss_low_cnt;
         K_RISE:  return rise_cnt;
         K_SEQ:   return {24'd0, mosi_seq};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: pin statistics on every falling edge, then compare whatever is due now.
   initial begin
      exp_t        keep_q[$];
      logic [31:0] act;
      forever begin
         @(negedge clk);
         if (clr_req != clr_seen) begin
            ss_low_cnt = 0;
            rise_cnt   = 0;
            mosi_seq   = 8'h00;
            clr_seen   = clr_req;
         end
         if (!ss) ss_low_cnt++;
         if (sclk && !sclk_prev) begin
            rise_cnt++;
            mosi_seq = {mosi_seq[6:0], mosi};
         end
         sclk_prev = sclk;
         keep_q = {};
         foreach (sb_q[i]) begin
            if (sb_q[i].due == cyc) begin
               act = actual(sb_q[i].kind);
               n_cmp++;
               if (act !== sb_q[i].exp) begin
                  n_err++;
                  $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                           sb_q[i].name, act, sb_q[i].exp, cyc);
               end
            end else if (sb_q[i].due < cyc) begin
               n_cmp++;
               n_err++;
               $display("FAIL %s: missed its cycle %0d, want 0x%0h", sb_q[i].name,
                        sb_q[i].due, sb_q[i].exp);
            end else begin
               keep_q.push_back(sb_q[i]);
            end
         end
         sb_q = keep_q;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic expect_at(input kind_e k, input logic [31:0] e, input string nm, input int due);
      exp_t it;
      it.kind = k;
      it.exp  = e;
      it.name = nm;
      it.due  = due;
      sb_q.push_back(it);
   endtask

   task automatic clr_counts();
      clr_req++;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      addr  = BASE | {28'd0, off};
      wdata = d;
      we    = 1'b1;
      step();
      we    = 1'b0;
      addr  = 32'd0;
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] e, input string nm);
      addr = BASE | {28'd0, off};
      re   = 1'b1;
      expect_at(K_RDATA, e, nm, cyc);
      step();
      re   = 1'b0;
      addr = 32'd0;
   endtask

   task automatic foreign(input logic [31:0] a, input logic [31:0] d, input string nm);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      re    = 1'b1;
      expect_at(K_SEL, 32'd0, {nm, "_sel"}, cyc);
      expect_at(K_RDATA, 32'd0, {nm, "_rdata"}, cyc);
      step();
      we    = 1'b0;
      re    = 1'b0;
      addr  = 32'd0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; addr = 32'd0; wdata = 32'd0; we = 1'b0; re = 1'b0;
      loop_en = 1'b1; miso_val = 1'b0;
      #1;
      repeat (3) step();
      rst = 1'b0;

      // Reset state
      expect_at(K_SS, 32'd1, "rst_ss", cyc);
      expect_at(K_SCLK, 32'd0, "rst_sclk", cyc);
      expect_at(K_MOSI, 32'd0, "rst_mosi", cyc);
      expect_at(K_IRQ, 32'd0, "rst_irq", cyc);
      rd(OFF_STAT, 32'h0, "rst_status");
      rd(OFF_CTRL, 32'h001, "rst_ctrl");
      rd(OFF_RX, 32'h0, "rst_rx");

      // 0xA5 loopback, H=2
      t0 = cyc;
      clr_counts();
      expect_at(K_SS, 32'd0, "a5_ss_setup", t0 + 1);
      expect_at(K_MOSI, 32'd1, "a5_mosi_bit7", t0 + 1);
      expect_at(K_SCLK, 32'd0, "a5_sclk_setup", t0 + 2);
      expect_at(K_SCLK, 32'd1, "a5_sclk_first_rise", t0 + 3);
      expect_at(K_SS, 32'd0, "a5_ss_last_hold", t0 + 36);
      expect_at(K_SS, 32'd1, "a5_ss_end", t0 + 37);
      expect_at(K_SSLOW, 32'd36, "a5_ss_low_cycles", t0 + 37);
      expect_at(K_RISE, 32'd8, "a5_rising_edges", t0 + 37);
      expect_at(K_SEQ, 32'hA5, "a5_mosi_seq", t0 + 37);
      wr(OFF_TX, 32'hA5);
      rd(OFF_STAT, 32'h1, "a5_status_busy");
      wait_until(t0 + 37);
      rd(OFF_STAT, 32'h2, "a5_status_done");
      rd(OFF_RX, 32'hA5, "a5_rx");
      rd(OFF_STAT, 32'h0, "a5_status_cleared");

      // Interrupt with miso tied high
      wr(OFF_CTRL, 32'h101);
      loop_en = 1'b0; miso_val = 1'b1;
      t0 = cyc;
      expect_at(K_IRQ, 32'd0, "irq_before_done", t0 + 36);
      expect_at(K_IRQ, 32'd1, "irq_at_done", t0 + 37);
      wr(OFF_TX, 32'h3C);
      wait_until(t0 + 37);
      rd(OFF_RX, 32'hFF, "irq_rx_ff");
      expect_at(K_IRQ, 32'd0, "irq_dropped", cyc);
      rd(OFF_STAT, 32'h0, "irq_status_after_read");

      // Overrun
      wr(OFF_CTRL, 32'h001);
      loop_en = 1'b1;
      t0 = cyc;
      clr_counts();
      expect_at(K_SEQ, 32'h11, "ovr_mosi_seq", t0 + 37);
      wr(OFF_TX, 32'h11);
      wait_until(t0 + 5);
      wr(OFF_TX, 32'h22);
      rd(OFF_STAT, 32'h5, "ovr_status");
      wait_until(t0 + 37);
      wr(OFF_STAT, 32'h4);
      rd(OFF_STAT, 32'h2, "ovr_cleared");
      wr(OFF_STAT, 32'h2);
      rd(OFF_STAT, 32'h0, "done_w1c");
      rd(OFF_RX, 32'h11, "ovr_rx_first_byte");

      // CLKDIV write while busy is ignored; then H=4
      t0 = cyc;
      wr(OFF_TX, 32'h5A);
      wait_until(t0 + 3);
      wr(OFF_CTRL, 32'h003);
      rd(OFF_CTRL, 32'h001, "div_ignored_busy");
      wait_until(t0 + 37);
      wr(OFF_CTRL, 32'h003);
      rd(OFF_CTRL, 32'h003, "div_set_idle");
      t0 = cyc;
      clr_counts();
      expect_at(K_SCLK, 32'd0, "h4_sclk_setup_end", t0 + 4);
      expect_at(K_SCLK, 32'd1, "h4_sclk_rise", t0 + 5);
      expect_at(K_SCLK, 32'd1, "h4_sclk_high_end", t0 + 8);
      expect_at(K_SCLK, 32'd0, "h4_sclk_fall", t0 + 9);
      expect_at(K_SCLK, 32'd0, "h4_sclk_low_end", t0 + 12);
      expect_at(K_SCLK, 32'd1, "h4_sclk_rise2", t0 + 13);
      expect_at(K_SS, 32'd0, "h4_ss_hold", t0 + 72);
      expect_at(K_SS, 32'd1, "h4_ss_end", t0 + 73);
      expect_at(K_RISE, 32'd8, "h4_rising_edges", t0 + 73);
      expect_at(K_SSLOW, 32'd72, "h4_ss_low_cycles", t0 + 73);
      wr(OFF_TX, 32'h96);
      wait_until(t0 + 73);
      rd(OFF_STAT, 32'h2, "h4_status_done");

      // Reset at the 5th sclk edge, with done, overrun and rx_byte all non-zero
      t0 = cyc;
      expect_at(K_SCLK, 32'd0, "rst5_sclk_low", t0 + 20);
      expect_at(K_SCLK, 32'd1, "rst5_fifth_edge", t0 + 21);
      wr(OFF_TX, 32'h77);
      wait_until(t0 + 2);
      wr(OFF_TX, 32'h01);
      rd(OFF_STAT, 32'h7, "rst5_status_pre");
      wait_until(t0 + 21);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_at(K_SS, 32'd1, "rst5_ss", cyc);
      expect_at(K_SCLK, 32'd0, "rst5_sclk", cyc);
      expect_at(K_MOSI, 32'd0, "rst5_mosi", cyc);
      rd(OFF_STAT, 32'h0, "rst5_status");
      rd(OFF_RX, 32'h0, "rst5_rx");
      rd(OFF_CTRL, 32'h001, "rst5_ctrl");
      t0 = cyc;
      clr_counts();
      expect_at(K_SS, 32'd0, "c3_ss_hold", t0 + 36);
      expect_at(K_SS, 32'd1, "c3_ss_end", t0 + 37);
      expect_at(K_RISE, 32'd8, "c3_rising_edges", t0 + 37);
      expect_at(K_SEQ, 32'hC3, "c3_mosi_seq", t0 + 37);
      wr(OFF_TX, 32'hC3);
      wait_until(t0 + 37);
      rd(OFF_RX, 32'hC3, "c3_rx");
      rd(OFF_STAT, 32'h0, "c3_status");

      // Outside the window: no select, no data, no side effects
      foreign(32'h4000_0010, 32'h0000_00AA, "off10_tx");
      foreign(32'h4000_001C, 32'h0000_01FF, "off1c_ctrl");
      foreign(32'h5000_0000, 32'h0000_00AA, "base_tx");
      foreign(32'h5000_000C, 32'h0000_01FF, "base_ctrl");
      expect_at(K_SEL, 32'd1, "in_window_sel", cyc);
      expect_at(K_SS, 32'd1, "foreign_ss_idle", cyc);
      rd(OFF_STAT, 32'h0, "foreign_status");
      rd(OFF_CTRL, 32'h001, "foreign_ctrl");

      step();
      step();
      foreach (sb_q[i]) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: never compared, want 0x%0h at cycle %0d", sb_q[i].name,
                  sb_q[i].exp, sb_q[i].due);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
